// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit:
// state codes, opcode/funct values, ALU ops and datapath mux selectors.
package mc_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_REXEC  = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_IEXEC  = 4'd10;
    localparam logic [3:0] S_IWB    = 4'd11;
    localparam logic [3:0] S_HALT   = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_CMP = 3'b111;

    localparam logic [1:0] SRCB_B   = 2'd0;
    localparam logic [1:0] SRCB_4   = 2'd1;
    localparam logic [1:0] SRCB_SE  = 2'd2;
    localparam logic [1:0] SRCB_SE2 = 2'd3;

    localparam logic [1:0] PCS_ALU  = 2'd0;
    localparam logic [1:0] PCS_HOLD = 2'd1;
    localparam logic [1:0] PCS_JUMP = 2'd2;

    typedef struct packed {
        logic       pc_wr;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // States whose exit back to FETCH retires an instruction.
    function automatic logic is_terminal(input logic [3:0] s);
        return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RWB) ||
               (s == S_BRANCH) || (s == S_JUMP) || (s == S_IWB);
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// R-type funct field to ALU operation; valid drops for unsupported funct.
module mc_alu_decode
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] op,
    output logic       valid
);

    always_comb begin
        op    = ALU_ADD;
        valid = 1'b1;
        unique case (1'b1)
            (funct == FN_ADD): op = ALU_ADD;
            (funct == FN_SUB): op = ALU_SUB;
            (funct == FN_AND): op = ALU_AND;
            (funct == FN_OR):  op = ALU_OR;
            (funct == FN_XOR): op = ALU_XOR;
            default:           valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Control FSM for the multi-cycle MIPS-subset datapath, with single-step,
// halt instruction, illegal-opcode trap and retired-instruction counter.
module mc_control_unit
    import mc_pkg::*;
#(
    parameter bit         ILLEGAL_TRAP = 1'b1,
    parameter int         CNT_W        = 16,
    parameter logic [5:0] HALT_OP      = 6'h3F
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             step_en,
    input  logic             step,
    output logic             PCWr,
    output logic             Iord,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRwrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       Operation_ALU,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       step_mode;
    logic       advance;
    logic       bad;
    logic       we_ok;
    logic [2:0] fn_op;
    logic       fn_valid;
    ctrl_t      ctl;

    mc_alu_decode u_alu_decode (
        .funct (funct),
        .op    (fn_op),
        .valid (fn_valid)
    );

    // step_en is registered so a change only affects the following cycle.
    assign advance = !step_mode || step;

    always_comb begin
        state_d = state_q;
        bad     = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
                else if (opcode == OP_RTYPE)            state_d = S_REXEC;
                else if (opcode == OP_BEQ)              state_d = S_BRANCH;
                else if (opcode == OP_J)                state_d = S_JUMP;
                else if (opcode == OP_ADDI)             state_d = S_IEXEC;
                else if (opcode == HALT_OP)             state_d = S_HALT;
                else                                    bad     = 1'b1;
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_REXEC:  begin
                if (fn_valid) state_d = S_RWB;
                else          bad     = 1'b1;
            end
            S_IEXEC:  state_d = S_IWB;
            S_MEMWB, S_MEMWR, S_RWB,
            S_BRANCH, S_JUMP, S_IWB: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
        if (bad) state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            step_mode   <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            step_mode <= step_en;
            if (advance) begin
                state_q <= state_d;
                if (bad && ILLEGAL_TRAP) illegal <= 1'b1;
                if (is_terminal(state_q))
                    instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        ctl = '0;
        case (state_q)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.ir_write  = 1'b1;
                ctl.alu_src_b = SRCB_4;
                ctl.pc_source = PCS_ALU;
                ctl.pc_wr     = 1'b1;
            end
            S_DECODE: ctl.alu_src_b = SRCB_SE2;
            S_MEMADR, S_IEXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_SE;
            end
            S_MEMRD: begin
                ctl.iord     = 1'b1;
                ctl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctl.mem_to_reg = 1'b1;
                ctl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctl.iord      = 1'b1;
                ctl.mem_write = 1'b1;
            end
            S_REXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_op    = fn_op;
            end
            S_RWB: begin
                ctl.reg_dst   = 1'b1;
                ctl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = ALU_CMP;
                ctl.pc_source = PCS_HOLD;
                ctl.pc_wr     = zero;
            end
            S_JUMP: begin
                ctl.pc_source = PCS_JUMP;
                ctl.pc_wr     = 1'b1;
            end
            S_IWB: ctl.reg_write = 1'b1;
            default: ;
        endcase
    end

    // Write enables are suppressed during reset and on held step cycles.
    assign we_ok         = advance && !reset;
    assign PCWr          = ctl.pc_wr     && we_ok;
    assign IRwrite       = ctl.ir_write  && we_ok;
    assign RegWrite      = ctl.reg_write && we_ok;
    assign MemWrite      = ctl.mem_write && we_ok;
    assign Iord          = ctl.iord;
    assign MemRead       = ctl.mem_read;
    assign MemtoReg      = ctl.mem_to_reg;
    assign RegDst        = ctl.reg_dst;
    assign ALUSrcA       = ctl.alu_src_a;
    assign ALUSrcB       = ctl.alu_src_b;
    assign Operation_ALU = ctl.alu_op;
    assign PCSource      = ctl.pc_source;
    assign state         = state_q;
    assign halted        = (state_q == S_HALT);

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: a trapping 16-bit-counter unit
// and a non-trapping 2-bit-counter unit run the same instruction stream.
module tb_mc_control_unit;

    typedef struct {
        string       nm;
        logic        rs;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        sen;
        logic        stp;
        logic [3:0]  st;
        logic [15:0] ct;
        logic [15:0] cnt;
        logic        ill;
    } vec_t;

    // Control vector order: PCWr Iord MemRead MemWrite IRwrite MemtoReg
    // RegWrite RegDst ALUSrcA | ALUSrcB | Operation_ALU | PCSource
    localparam logic [15:0] C_FETCH  = {9'b101010000, 2'd1, 3'd0, 2'd0};
    localparam logic [15:0] C_FETCHM = {9'b001000000, 2'd1, 3'd0, 2'd0};
    localparam logic [15:0] C_DECODE = {9'b000000000, 2'd3, 3'd0, 2'd0};
    localparam logic [15:0] C_MEMADR = {9'b000000001, 2'd2, 3'd0, 2'd0};
    localparam logic [15:0] C_MEMRD  = {9'b011000000, 2'd0, 3'd0, 2'd0};
    localparam logic [15:0] C_MEMWB  = {9'b000001100, 2'd0, 3'd0, 2'd0};
    localparam logic [15:0] C_MEMWR  = {9'b010100000, 2'd0, 3'd0, 2'd0};
    localparam logic [15:0] C_RWB    = {9'b000000110, 2'd0, 3'd0, 2'd0};
    localparam logic [15:0] C_BR1    = {9'b100000001, 2'd0, 3'd7, 2'd1};
    localparam logic [15:0] C_BR0    = {9'b000000001, 2'd0, 3'd7, 2'd1};
    localparam logic [15:0] C_JUMP   = {9'b100000000, 2'd0, 3'd0, 2'd2};
    localparam logic [15:0] C_JUMPM  = {9'b000000000, 2'd0, 3'd0, 2'd2};
    localparam logic [15:0] C_IEXEC  = {9'b000000001, 2'd2, 3'd0, 2'd0};
    localparam logic [15:0] C_IWB    = {9'b000000100, 2'd0, 3'd0, 2'd0};
    localparam logic [15:0] C_HALT   = 16'h0000;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        step_en;
    logic        step;

    logic        PCWr, Iord, MemRead, MemWrite, IRwrite;
    logic        MemtoReg, RegWrite, RegDst, ALUSrcA;
    logic [1:0]  ALUSrcB, PCSource;
    logic [2:0]  Operation_ALU;
    logic [3:0]  state;
    logic        halted, illegal;
    logic [15:0] instr_count;

    logic        PCWr2, Iord2, MemRead2, MemWrite2, IRwrite2;
    logic        MemtoReg2, RegWrite2, RegDst2, ALUSrcA2;
    logic [1:0]  ALUSrcB2, PCSource2;
    logic [2:0]  Operation_ALU2;
    logic [3:0]  state2;
    logic        halted2, illegal2;
    logic [1:0]  instr_count2;

    int   checks = 0;
    int   errors = 0;
    int   e_cnt  = 0;
    logic e_ill  = 1'b0;
    vec_t tbl[$];
    vec_t sb[$];
    vec_t e;

    mc_control_unit #(.ILLEGAL_TRAP(1'b1), .CNT_W(16), .HALT_OP(6'h3F)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .step_en(step_en), .step(step),
        .PCWr(PCWr), .Iord(Iord), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRwrite(IRwrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .Operation_ALU(Operation_ALU), .PCSource(PCSource),
        .state(state), .halted(halted), .illegal(illegal),
        .instr_count(instr_count)
    );

    // Different HALT_OP, so 0x3F is an illegal NOP for this instance.
    mc_control_unit #(.ILLEGAL_TRAP(1'b0), .CNT_W(2), .HALT_OP(6'h3E)) dut2 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .step_en(step_en), .step(step),
        .PCWr(PCWr2), .Iord(Iord2), .MemRead(MemRead2), .MemWrite(MemWrite2),
        .IRwrite(IRwrite2), .MemtoReg(MemtoReg2), .RegWrite(RegWrite2),
        .RegDst(RegDst2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2),
        .Operation_ALU(Operation_ALU2), .PCSource(PCSource2),
        .state(state2), .halted(halted2), .illegal(illegal2),
        .instr_count(instr_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [15:0] ctl1 = {PCWr, Iord, MemRead, MemWrite, IRwrite, MemtoReg,
                        RegWrite, RegDst, ALUSrcA, ALUSrcB, Operation_ALU,
                        PCSource};

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({state, ctl1, instr_count, illegal, halted} !==
                {e.st, e.ct, e.cnt, e.ill, (e.st == 4'd15)}) begin
                errors++;
                $display("FAIL %s: got st=%0d ctl=%h cnt=%0d ill=%b halt=%b want st=%0d ctl=%h cnt=%0d ill=%b halt=%b",
                         e.nm, state, ctl1, instr_count, illegal, halted,
                         e.st, e.ct, e.cnt, e.ill, (e.st == 4'd15));
            end
            checks++;
            if ({instr_count2, illegal2, halted2} !== {e.cnt[1:0], 2'b00}) begin
                errors++;
                $display("FAIL %s/nop2: got cnt=%0d ill=%b halt=%b want cnt=%0d ill=0 halt=0",
                         e.nm, instr_count2, illegal2, halted2, e.cnt[1:0]);
            end
        end
    end

    function automatic logic [15:0] rx(input logic [2:0] o);
        return {9'b000000001, 2'd0, o, 2'd0};
    endfunction

    task automatic v(input string nm, input logic rs, input logic [5:0] op,
                     input logic [5:0] fn, input logic z, input logic sen,
                     input logic stp, input logic [3:0] st,
                     input logic [15:0] ct);
        vec_t r;
        r.nm = nm; r.rs = rs; r.op = op; r.fn = fn; r.z = z;
        r.sen = sen; r.stp = stp; r.st = st; r.ct = ct;
        r.cnt = 16'(e_cnt); r.ill = e_ill;
        tbl.push_back(r);
    endtask

    task automatic fd(input string nm, input logic [5:0] op,
                      input logic [5:0] fn, input logic z);
        v({nm, "_f"}, 1'b0, op, fn, z, 1'b0, 1'b0, 4'd0, C_FETCH);
        v({nm, "_d"}, 1'b0, op, fn, z, 1'b0, 1'b0, 4'd1, C_DECODE);
    endtask

    task automatic rst_rec(input string nm);
        e_cnt = 0;
        e_ill = 1'b0;
        v(nm, 1'b1, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 4'd0, C_FETCHM);
    endtask

    initial begin
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
        step_en = 1'b0; step = 1'b0;

        rst_rec("rst_a");
        rst_rec("rst_b");
        fd("add", 6'h00, 6'h20, 0);
        v("add_x", 0, 6'h00, 6'h20, 0, 0, 0, 4'd6, rx(3'b000));
        v("add_w", 0, 6'h00, 6'h20, 0, 0, 0, 4'd7, C_RWB); e_cnt++;
        fd("sub", 6'h00, 6'h22, 0);
        v("sub_x", 0, 6'h00, 6'h22, 0, 0, 0, 4'd6, rx(3'b001));
        v("sub_w", 0, 6'h00, 6'h22, 0, 0, 0, 4'd7, C_RWB); e_cnt++;
        fd("xor", 6'h00, 6'h26, 0);
        v("xor_x", 0, 6'h00, 6'h26, 0, 0, 0, 4'd6, rx(3'b100));
        v("xor_w", 0, 6'h00, 6'h26, 0, 0, 0, 4'd7, C_RWB); e_cnt++;
        fd("lw", 6'h23, 6'h00, 0);
        v("lw_a", 0, 6'h23, 6'h00, 0, 0, 0, 4'd2, C_MEMADR);
        v("lw_r", 0, 6'h23, 6'h00, 0, 0, 0, 4'd3, C_MEMRD);
        v("lw_w", 0, 6'h23, 6'h00, 0, 0, 0, 4'd4, C_MEMWB); e_cnt++;
        fd("sw", 6'h2B, 6'h00, 0);
        v("sw_a", 0, 6'h2B, 6'h00, 0, 0, 0, 4'd2, C_MEMADR);
        v("sw_w", 0, 6'h2B, 6'h00, 0, 0, 0, 4'd5, C_MEMWR); e_cnt++;
        fd("beq1", 6'h04, 6'h00, 1);
        v("beq1_b", 0, 6'h04, 6'h00, 1, 0, 0, 4'd8, C_BR1); e_cnt++;
        fd("beq0", 6'h04, 6'h00, 0);
        v("beq0_b", 0, 6'h04, 6'h00, 0, 0, 0, 4'd8, C_BR0); e_cnt++;
        fd("jmp", 6'h02, 6'h00, 0);
        v("jmp_j", 0, 6'h02, 6'h00, 0, 0, 0, 4'd9, C_JUMP); e_cnt++;
        fd("addi", 6'h08, 6'h00, 0);
        v("addi_x", 0, 6'h08, 6'h00, 0, 0, 0, 4'd10, C_IEXEC);
        v("addi_w", 0, 6'h08, 6'h00, 0, 0, 0, 4'd11, C_IWB); e_cnt++;
        fd("hlt", 6'h3F, 6'h00, 0);
        for (int i = 0; i < 3; i++)
            v("hlt_h", 0, 6'h3F, 6'h00, 0, 0, 0, 4'd15, C_HALT);

        rst_rec("rst_c");
        fd("ill", 6'h11, 6'h00, 0);
        e_ill = 1'b1;
        for (int i = 0; i < 20; i++)
            v("ill_h", 0, 6'h11, 6'h00, 0, 0, 0, 4'd15, C_HALT);
        rst_rec("rst_clr");

        fd("badfn", 6'h00, 6'h30, 0);
        v("badfn_x", 0, 6'h00, 6'h30, 0, 0, 0, 4'd6, rx(3'b000));
        e_ill = 1'b1;
        for (int i = 0; i < 5; i++)
            v("badfn_h", 0, 6'h00, 6'h30, 0, 0, 0, 4'd15, C_HALT);
        rst_rec("rst_d");

        v("st_f0", 0, 6'h02, 0, 0, 1, 0, 4'd0, C_FETCH);
        for (int i = 0; i < 3; i++)
            v("st_dhold", 0, 6'h02, 0, 0, 1, 0, 4'd1, C_DECODE);
        v("st_dstep", 0, 6'h02, 0, 0, 1, 1, 4'd1, C_DECODE);
        for (int i = 0; i < 3; i++)
            v("st_jhold", 0, 6'h02, 0, 0, 1, 0, 4'd9, C_JUMPM);
        v("st_jstep", 0, 6'h02, 0, 0, 1, 1, 4'd9, C_JUMP); e_cnt++;
        for (int i = 0; i < 3; i++)
            v("st_fhold", 0, 6'h02, 0, 0, 1, 0, 4'd0, C_FETCHM);
        v("st_fstep", 0, 6'h02, 0, 0, 1, 1, 4'd0, C_FETCH);
        v("st_off", 0, 6'h02, 0, 0, 0, 0, 4'd1, C_DECODE);
        v("st_free_d", 0, 6'h02, 0, 0, 0, 0, 4'd1, C_DECODE);
        v("st_free_j", 0, 6'h02, 0, 0, 0, 0, 4'd9, C_JUMP); e_cnt++;
        v("st_free_f", 0, 6'h02, 0, 0, 0, 0, 4'd0, C_FETCH);
        rst_rec("rst_e");

        for (int k = 0; k < 5; k++) begin
            fd("wrap", 6'h02, 6'h00, 0);
            v("wrap_j", 0, 6'h02, 6'h00, 0, 0, 0, 4'd9, C_JUMP); e_cnt++;
        end
        v("wrap_end", 0, 6'h02, 6'h00, 0, 0, 0, 4'd0, C_FETCH);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            reset   = tbl[i].rs;
            opcode  = tbl[i].op;
            funct   = tbl[i].fn;
            zero    = tbl[i].z;
            step_en = tbl[i].sen;
            step    = tbl[i].stp;
            sb.push_back(tbl[i]);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
